// File: rtl/mem2_arbiter.sv
`default_nettype none
//============================================================================
// Module      : mem2_arbiter (with package mem2_arbiter_pkg)
// Description : Two-requester arbiter in front of the memory2 BRAM. The read
//               and write paths each hold a one-entry pending slot per
//               requester and use a 1-bit round-robin pointer. A read waits
//               for the same requester's pending write to the same address.
//               Read returns are routed back to their owner with a tag
//               shift register.
//               Optional feature macro: MEM2_ARB_STATS_EN builds saturating
//               grant/conflict counters. Without it, the stat_* outputs
//               are tied to zero.
// Revision    : 1.0 - initial release
//============================================================================

package mem2_arbiter_pkg;
    localparam int c_addr_w = 16;
    localparam int c_data_w = 32;

    typedef struct packed {
        logic                re;
        logic [c_addr_w-1:0] raddr;
    } bram_request;

    typedef struct packed {
        logic                we;
        logic [c_addr_w-1:0] waddr;
        logic [c_data_w-1:0] wdata;
    } bram_write;

    typedef struct packed {
        logic                valid;
        logic [c_data_w-1:0] rdata;
    } bram_read;
endpackage

module mem2_arbiter
    import mem2_arbiter_pkg::*;
#(
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  bram_request req_request    [2],
    input  bram_write   req_write      [2],
    output bram_read    req_read       [2],
    output logic        rd_ready       [2],
    output logic        wr_ready       [2],
    output bram_request mem_request,
    output bram_write   mem_write,
    input  bram_read    mem_read,
    output logic        proto_err,
    output logic [31:0] stat_rd_grants [2],
    output logic [31:0] stat_wr_grants [2],
    output logic [31:0] stat_conflicts
);

    localparam int c_tag_last = READ_LATENCY - 1;

    // Pending slots and round-robin pointers
    logic [1:0]          r_prd_v;
    logic [c_addr_w-1:0] r_prd_addr [2];
    logic [1:0]          r_pwr_v;
    logic [c_addr_w-1:0] r_pwr_addr [2];
    logic [c_data_w-1:0] r_pwr_data [2];
    logic                r_rd_ptr;
    logic                r_wr_ptr;

    // Registered memory commands and read-return bookkeeping
    bram_request             r_mem_request;
    bram_write               r_mem_write;
    logic                    r_rd_owner;
    logic [READ_LATENCY-1:0] r_tag_v;
    logic [READ_LATENCY-1:0] r_tag_id;
    logic [1:0]              r_rv;
    logic [c_data_w-1:0]     r_rdata [2];
    logic                    r_proto_err;

    // Candidate selection
    logic [1:0]          w_rd_cand;
    logic [1:0]          w_rd_elig;
    logic [1:0]          w_rd_gnt;
    logic [c_addr_w-1:0] w_rd_caddr [2];
    logic [1:0]          w_wr_cand;
    logic [1:0]          w_wr_gnt;
    logic [c_addr_w-1:0] w_wr_caddr [2];
    logic [c_data_w-1:0] w_wr_cdata [2];
    logic                w_proto_viol;

    // One-hot grant: with two candidates the pointer decides, otherwise the
    // lone candidate (if any) wins. The next pointer is always grant[0],
    // i.e. it points away from whoever was just served.
    function automatic logic [1:0] f_rr_grant(input logic [1:0] elig, input logic ptr);
        if (elig == 2'b11) begin
            return ptr ? 2'b10 : 2'b01;
        end
        return elig;
    endfunction

    // Form read/write candidates, apply the same-requester RAW block, arbitrate
    always_comb begin
        w_proto_viol = 1'b0;
        for (int i = 0; i < 2; i++) begin
            w_rd_cand[i]  = r_prd_v[i] | req_request[i].re;
            w_rd_caddr[i] = r_prd_v[i] ? r_prd_addr[i] : req_request[i].raddr;
            w_rd_elig[i]  = w_rd_cand[i] &
                            ~(r_pwr_v[i] & (r_pwr_addr[i] == w_rd_caddr[i]));
            w_wr_cand[i]  = r_pwr_v[i] | req_write[i].we;
            w_wr_caddr[i] = r_pwr_v[i] ? r_pwr_addr[i] : req_write[i].waddr;
            w_wr_cdata[i] = r_pwr_v[i] ? r_pwr_data[i] : req_write[i].wdata;
            w_proto_viol  = w_proto_viol |
                            (req_request[i].re & r_prd_v[i]) |
                            (req_write[i].we & r_pwr_v[i]);
        end
        w_rd_gnt = f_rr_grant(w_rd_elig, r_rd_ptr);
        w_wr_gnt = f_rr_grant(w_wr_cand, r_wr_ptr);
    end

    // Pending slots, pointers and the registered single-cycle memory pulses
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_prd_v       <= '0;
            r_pwr_v       <= '0;
            r_rd_ptr      <= 1'b0;
            r_wr_ptr      <= 1'b0;
            r_mem_request <= '0;
            r_mem_write   <= '0;
            r_rd_owner    <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_prd_addr[i] <= '0;
                r_pwr_addr[i] <= '0;
                r_pwr_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_rd_cand[i]) begin
                    r_prd_v[i]    <= ~w_rd_gnt[i];
                    r_prd_addr[i] <= w_rd_caddr[i];
                end
                if (w_wr_cand[i]) begin
                    r_pwr_v[i]    <= ~w_wr_gnt[i];
                    r_pwr_addr[i] <= w_wr_caddr[i];
                    r_pwr_data[i] <= w_wr_cdata[i];
                end
            end
            if (|w_rd_elig) begin
                r_rd_ptr <= w_rd_gnt[0];
            end
            if (|w_wr_cand) begin
                r_wr_ptr <= w_wr_gnt[0];
            end
            r_mem_request.re <= |w_rd_gnt;
            if (|w_rd_gnt) begin
                r_mem_request.raddr <= w_rd_gnt[1] ? w_rd_caddr[1] : w_rd_caddr[0];
                r_rd_owner          <= w_rd_gnt[1];
            end
            r_mem_write.we <= |w_wr_gnt;
            if (|w_wr_gnt) begin
                r_mem_write.waddr <= w_wr_gnt[1] ? w_wr_caddr[1] : w_wr_caddr[0];
                r_mem_write.wdata <= w_wr_gnt[1] ? w_wr_cdata[1] : w_wr_cdata[0];
            end
        end
    end

    // Tag pipeline aligned with BRAM latency; route returns to their owner
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_tag_v  <= '0;
            r_tag_id <= '0;
            r_rv     <= '0;
            for (int i = 0; i < 2; i++) begin
                r_rdata[i] <= '0;
            end
        end else begin
            for (int k = c_tag_last; k > 0; k--) begin
                r_tag_v[k]  <= r_tag_v[k-1];
                r_tag_id[k] <= r_tag_id[k-1];
            end
            r_tag_v[0]  <= r_mem_request.re;
            r_tag_id[0] <= r_rd_owner;
            r_rv        <= '0;
            // A return with no tag at the end of the pipeline is dropped
            if (mem_read.valid && r_tag_v[c_tag_last]) begin
                r_rv[r_tag_id[c_tag_last]]    <= 1'b1;
                r_rdata[r_tag_id[c_tag_last]] <= mem_read.rdata;
            end
        end
    end

    // Sticky protocol-violation flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_proto_err <= 1'b0;
        end else if (w_proto_viol) begin
            r_proto_err <= 1'b1;
        end
    end

    assign mem_request = r_mem_request;
    assign mem_write   = r_mem_write;
    assign proto_err   = r_proto_err;

    generate
        for (genvar i = 0; i < 2; i++) begin : g_req_port
            assign rd_ready[i] = ~r_prd_v[i];
            assign wr_ready[i] = ~r_pwr_v[i];
            assign req_read[i] = {r_rv[i], r_rdata[i]};
        end
    endgenerate

`ifdef MEM2_ARB_STATS_EN
    logic [31:0] r_stat_rd [2];
    logic [31:0] r_stat_wr [2];
    logic [31:0] r_stat_cf;
    logic        w_conflict;

    function automatic logic [31:0] f_sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign w_conflict = (&w_rd_elig) | (&w_wr_cand);

    // Saturating per-requester grant counters and the conflict counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_stat_cf <= '0;
            for (int i = 0; i < 2; i++) begin
                r_stat_rd[i] <= '0;
                r_stat_wr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_rd_gnt[i]) begin
                    r_stat_rd[i] <= f_sat_inc(r_stat_rd[i]);
                end
                if (w_wr_gnt[i]) begin
                    r_stat_wr[i] <= f_sat_inc(r_stat_wr[i]);
                end
            end
            if (w_conflict) begin
                r_stat_cf <= f_sat_inc(r_stat_cf);
            end
        end
    end

    generate
        for (genvar i = 0; i < 2; i++) begin : g_stat_on
            assign stat_rd_grants[i] = r_stat_rd[i];
            assign stat_wr_grants[i] = r_stat_wr[i];
        end
    endgenerate
    assign stat_conflicts = r_stat_cf;
`else
    generate
        for (genvar i = 0; i < 2; i++) begin : g_stat_off
            assign stat_rd_grants[i] = 32'd0;
            assign stat_wr_grants[i] = 32'd0;
        end
    endgenerate
    assign stat_conflicts = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem2_arbiter.sv
`default_nettype none
//============================================================================
// Module      : tb_mem2_arbiter
// Description : Self-checking bench for mem2_arbiter. Directed scenarios,
//               then randomized traffic compared cycle by cycle against a
//               transaction-level reference model. A small BRAM stand-in
//               returns {addr, ~addr} READ_LATENCY cycles after each read
//               and may inject untagged returns. Expected stat values
//               follow MEM2_ARB_STATS_EN.
// Revision    : 1.0 - initial release
//============================================================================
module tb_mem2_arbiter;
    import mem2_arbiter_pkg::*;

    localparam int RL = 2;
`ifdef MEM2_ARB_STATS_EN
    localparam bit c_stats_on = 1'b1;
`else
    localparam bit c_stats_on = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    bram_request req_request [2];
    bram_write   req_write   [2];
    bram_read    req_read    [2];
    logic        rd_ready    [2];
    logic        wr_ready    [2];
    bram_request mem_request;
    bram_write   mem_write;
    bram_read    mem_read;
    logic        proto_err;
    logic [31:0] stat_rd_grants [2];
    logic [31:0] stat_wr_grants [2];
    logic [31:0] stat_conflicts;

    mem2_arbiter #(.READ_LATENCY(RL)) u_dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_request    (req_request),
        .req_write      (req_write),
        .req_read       (req_read),
        .rd_ready       (rd_ready),
        .wr_ready       (wr_ready),
        .mem_request    (mem_request),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .proto_err      (proto_err),
        .stat_rd_grants (stat_rd_grants),
        .stat_wr_grants (stat_wr_grants),
        .stat_conflicts (stat_conflicts)
    );

    function automatic logic [31:0] line_of(input logic [15:0] a);
        return {a, ~a};
    endfunction

    // BRAM stand-in
    bit          stray_en = 1'b0;
    logic [RL-1:0] env_v = '0;
    logic [31:0] env_d [RL];
    always @(posedge clk) begin
        for (int k = RL - 1; k > 0; k--) begin
            env_v[k] <= env_v[k-1];
            env_d[k] <= env_d[k-1];
        end
        if (mem_request.re) begin
            env_v[0] <= 1'b1;
            env_d[0] <= line_of(mem_request.raddr);
        end else begin
            env_v[0] <= stray_en && ($urandom_range(0, 7) == 0);
            env_d[0] <= $urandom;
        end
    end
    assign mem_read = {env_v[RL-1], env_d[RL-1]};

    // Checking
    int n_checks = 0;
    int n_pass   = 0;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Stimulus for the next cycle
    logic        s_rst_n;
    logic        s_re [2];
    logic [15:0] s_ra [2];
    logic        s_we [2];
    logic [15:0] s_wa [2];
    logic [31:0] s_wd [2];

    // Reference model: transaction view of the arbiter
    typedef struct {
        int          due;
        int          owner;
        logic [31:0] data;
    } dlv_t;
    dlv_t        m_dq [$];
    int          cyc;
    logic        m_prd_v [2];
    logic [15:0] m_prd_a [2];
    logic        m_pwr_v [2];
    logic [15:0] m_pwr_a [2];
    logic [31:0] m_pwr_d [2];
    int          m_rptr, m_wptr;
    logic        m_mem_re, m_mem_we;
    logic [15:0] m_mem_ra, m_mem_wa;
    logic [31:0] m_mem_wd;
    logic        m_rv [2];
    logic [31:0] m_rdata [2];
    logic        m_proto;
    int unsigned m_st_rd [2], m_st_wr [2], m_st_cf;

    task automatic model_reset();
        m_dq.delete();
        m_rptr = 0; m_wptr = 0;
        m_mem_re = 0; m_mem_we = 0; m_mem_ra = 0; m_mem_wa = 0; m_mem_wd = 0;
        m_proto = 0; m_st_cf = 0;
        for (int i = 0; i < 2; i++) begin
            m_prd_v[i] = 0; m_prd_a[i] = 0;
            m_pwr_v[i] = 0; m_pwr_a[i] = 0; m_pwr_d[i] = 0;
            m_rv[i] = 0; m_rdata[i] = 0;
            m_st_rd[i] = 0; m_st_wr[i] = 0;
        end
    endtask

    task automatic model_step();
        int rc[$];
        int wc[$];
        int w;
        logic [15:0] a;
        cyc++;
        if (!s_rst_n) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) m_rv[i] = 0;
        for (int k = m_dq.size() - 1; k >= 0; k--) begin
            if (m_dq[k].due == cyc) begin
                m_rv[m_dq[k].owner]    = 1;
                m_rdata[m_dq[k].owner] = m_dq[k].data;
                m_dq.delete(k);
            end
        end
        for (int i = 0; i < 2; i++) begin
            if ((s_re[i] && m_prd_v[i]) || (s_we[i] && m_pwr_v[i])) m_proto = 1;
        end
        // Reads: a held or fresh request, blocked by own pending write to the same address
        for (int i = 0; i < 2; i++) begin
            if (m_prd_v[i] || s_re[i]) begin
                a = m_prd_v[i] ? m_prd_a[i] : s_ra[i];
                if (!(m_pwr_v[i] && m_pwr_a[i] == a)) rc.push_back(i);
                m_prd_v[i] = 1;
                m_prd_a[i] = a;
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (m_pwr_v[i] || s_we[i]) begin
                if (!m_pwr_v[i]) begin
                    m_pwr_a[i] = s_wa[i];
                    m_pwr_d[i] = s_wd[i];
                end
                m_pwr_v[i] = 1;
                wc.push_back(i);
            end
        end
        if (rc.size() == 2 || wc.size() == 2) m_st_cf++;
        w = (rc.size() == 2) ? m_rptr : (rc.size() == 1) ? rc[0] : -1;
        m_mem_re = (w >= 0);
        if (w >= 0) begin
            m_rptr     = 1 - w;
            m_prd_v[w] = 0;
            m_mem_ra   = m_prd_a[w];
            m_dq.push_back('{due: cyc + RL + 1, owner: w, data: line_of(m_prd_a[w])});
            m_st_rd[w]++;
        end
        w = (wc.size() == 2) ? m_wptr : (wc.size() == 1) ? wc[0] : -1;
        m_mem_we = (w >= 0);
        if (w >= 0) begin
            m_wptr     = 1 - w;
            m_pwr_v[w] = 0;
            m_mem_wa   = m_pwr_a[w];
            m_mem_wd   = m_pwr_d[w];
            m_st_wr[w]++;
        end
    endtask

    function automatic logic [31:0] exp_stat(input int unsigned v);
        return c_stats_on ? v : 32'd0;
    endfunction

    task automatic compare_all();
        check("mem_re", mem_request.re, m_mem_re);
        if (m_mem_re) check("mem_raddr", mem_request.raddr, m_mem_ra);
        check("mem_we", mem_write.we, m_mem_we);
        if (m_mem_we) begin
            check("mem_waddr", mem_write.waddr, m_mem_wa);
            check("mem_wdata", mem_write.wdata, m_mem_wd);
        end
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rd_ready%0d", i), rd_ready[i], !m_prd_v[i]);
            check($sformatf("wr_ready%0d", i), wr_ready[i], !m_pwr_v[i]);
            check($sformatf("rd_valid%0d", i), req_read[i].valid, m_rv[i]);
            check($sformatf("rdata%0d", i), req_read[i].rdata, m_rdata[i]);
            check($sformatf("stat_rd%0d", i), stat_rd_grants[i], exp_stat(m_st_rd[i]));
            check($sformatf("stat_wr%0d", i), stat_wr_grants[i], exp_stat(m_st_wr[i]));
        end
        check("proto_err", proto_err, m_proto);
        check("stat_cf", stat_conflicts, exp_stat(m_st_cf));
    endtask

    // Apply one cycle of stimulus, advance the model, compare on the falling edge
    task automatic step();
        reset_n = s_rst_n;
        for (int i = 0; i < 2; i++) begin
            req_request[i].re    = s_re[i];
            req_request[i].raddr = s_ra[i];
            req_write[i].we      = s_we[i];
            req_write[i].waddr   = s_wa[i];
            req_write[i].wdata   = s_wd[i];
        end
        model_step();
        @(negedge clk);
        compare_all();
        for (int i = 0; i < 2; i++) begin
            s_re[i] = 0;
            s_we[i] = 0;
        end
    endtask

    task automatic do_reset();
        s_rst_n = 0;
        step();
        step();
        s_rst_n = 1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    logic [15:0] exp_wo [6];
    logic [15:0] seen_wa [$];
    int          n0, n1;

    initial begin
        exp_wo = '{16'h30, 16'h40, 16'h31, 16'h41, 16'h32, 16'h42};
        reset_n = 0;
        s_rst_n = 0;
        cyc     = 0;
        for (int i = 0; i < 2; i++) begin
            req_request[i] = '0;
            req_write[i]   = '0;
            s_re[i] = 0; s_ra[i] = 0; s_we[i] = 0; s_wa[i] = 0; s_wd[i] = 0;
        end
        model_reset();
        @(negedge clk);

        // Lone read from requester 0
        do_reset();
        check("rst_rd_ready0", rd_ready[0], 1);
        check("rst_wr_ready1", wr_ready[1], 1);
        check("rst_proto", proto_err, 0);
        s_re[0] = 1; s_ra[0] = 16'h10;
        step();
        check("s1_mem_re", mem_request.re, 1);
        check("s1_raddr", mem_request.raddr, 16'h10);
        step();
        check("s1_re_pulse", mem_request.re, 0);
        step();
        check("s1_mem_valid", mem_read.valid, 1);
        step();
        check("s1_v0", req_read[0].valid, 1);
        check("s1_line", req_read[0].rdata, 32'h0010_FFEF);
        check("s1_v1", req_read[1].valid, 0);
        step();
        check("s1_hold", req_read[0].rdata, 32'h0010_FFEF);

        // Simultaneous reads after reset
        do_reset();
        s_re[0] = 1; s_ra[0] = 16'h1;
        s_re[1] = 1; s_ra[1] = 16'h2;
        step();
        check("s2_first", mem_request.raddr, 16'h1);
        check("s2_ready1", rd_ready[1], 0);
        step();
        check("s2_second_re", mem_request.re, 1);
        check("s2_second", mem_request.raddr, 16'h2);
        check("s2_conflicts", stat_conflicts, exp_stat(1));
        idle(RL + 2);

        // Back-to-back writes from both requesters
        do_reset();
        n0 = 0; n1 = 0;
        seen_wa.delete();
        for (int c = 0; c < 20 && seen_wa.size() < 6; c++) begin
            if (n0 < 3 && !m_pwr_v[0]) begin
                s_we[0] = 1; s_wa[0] = 16'h30 + 16'(n0); s_wd[0] = 32'hD000_0000 + n0; n0++;
            end
            if (n1 < 3 && !m_pwr_v[1]) begin
                s_we[1] = 1; s_wa[1] = 16'h40 + 16'(n1); s_wd[1] = 32'hE000_0000 + n1; n1++;
            end
            step();
            if (mem_write.we) seen_wa.push_back(mem_write.waddr);
        end
        check("s3_count", seen_wa.size(), 6);
        for (int k = 0; k < seen_wa.size() && k < 6; k++) begin
            check($sformatf("s3_order%0d", k), seen_wa[k], exp_wo[k]);
        end

        // Read-after-write hazard on requester 1
        do_reset();
        s_we[0] = 1; s_wa[0] = 16'h50; s_wd[0] = 32'h1111_0000;
        s_we[1] = 1; s_wa[1] = 16'h20; s_wd[1] = 32'h2222_0000;
        step();
        check("s4_w0", mem_write.waddr, 16'h50);
        s_re[1] = 1; s_ra[1] = 16'h20;
        step();
        check("s4_w1_we", mem_write.we, 1);
        check("s4_w1", mem_write.waddr, 16'h20);
        check("s4_rd_held", mem_request.re, 0);
        step();
        check("s4_rd_re", mem_request.re, 1);
        check("s4_rd", mem_request.raddr, 16'h20);
        idle(RL + 2);

        // Protocol violation
        do_reset();
        s_re[0] = 1; s_ra[0] = 16'h3;
        step();
        s_re[0] = 1; s_ra[0] = 16'h4;
        s_re[1] = 1; s_ra[1] = 16'h5;
        step();
        check("s5_not_ready", rd_ready[0], 0);
        s_re[0] = 1; s_ra[0] = 16'h7;
        step();
        check("s5_proto", proto_err, 1);
        check("s5_held_addr", mem_request.raddr, 16'h4);
        idle(4);
        check("s5_sticky", proto_err, 1);

        // Reset with a read in flight
        do_reset();
        s_re[0] = 1; s_ra[0] = 16'h10;
        step();
        step();
        s_rst_n = 0;
        step();
        s_rst_n = 1;
        check("s6_rst_re", mem_request.re, 0);
        check("s6_rst_proto", proto_err, 0);
        for (int k = 0; k < RL + 3; k++) begin
            step();
            check("s6_no_valid", req_read[0].valid, 0);
        end

        // Randomized traffic with occasional resets, violations and stray returns
        stray_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            s_rst_n = ($urandom_range(0, 249) != 0);
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 1) == 1 && (!m_prd_v[i] || $urandom_range(0, 63) == 0)) begin
                    s_re[i] = 1;
                    s_ra[i] = 16'($urandom_range(0, 7));
                end
                if ($urandom_range(0, 1) == 1 && (!m_pwr_v[i] || $urandom_range(0, 63) == 0)) begin
                    s_we[i] = 1;
                    s_wa[i] = 16'($urandom_range(0, 7));
                    s_wd[i] = $urandom;
                end
            end
            step();
        end
        stray_en = 1'b0;
        s_rst_n  = 1;
        idle(RL + 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
